axis_byte_bridge: RTL and testbench



---
 rtl/axis_byte_bridge.sv | 163 ++++++++++++++++
 tb/tb_axis_byte_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_bridge.sv
// axis_byte_bridge: byte-wide host link <-> processor AXI-Stream ports.
//   Packer  : host bytes (MSB-first) -> INP_WIDTH-bit words on m_axis.
//   Unpacker: OUT_WIDTH-bit words from s_axis -> host bytes (MSB-first).
// Packer and unpacker are fully independent and may run concurrently.
// Optional feature macro: AXIS_BYTE_BRIDGE_TLAST_EN
//   adds s_byte_tlast (early tlast aborts the partial word and sets the
//   sticky frame_err), m_byte_tlast (final byte of each output word).
module axis_byte_bridge #(
  parameter int INP_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [7:0]           s_byte_tdata,
  input  logic                 s_byte_tvalid,
  output logic                 s_byte_tready,
  output logic [INP_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic [OUT_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [7:0]           m_byte_tdata,
  output logic                 m_byte_tvalid,
  input  logic                 m_byte_tready
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
  ,
  input  logic                 s_byte_tlast,
  output logic                 m_byte_tlast,
  output logic                 frame_err
`endif
);

  localparam int INP_BYTES = INP_WIDTH / 8;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int PCW       = (INP_BYTES > 1) ? $clog2(INP_BYTES) : 1;
  localparam int UCW       = $clog2(OUT_BYTES + 1);

  localparam logic [PCW-1:0] PCNT_LAST = PCW'(INP_BYTES - 1);
  localparam logic [PCW-1:0] PCNT_ONE  = PCW'(1);
  localparam logic [UCW-1:0] UCNT_FULL = UCW'(OUT_BYTES);
  localparam logic [UCW-1:0] UCNT_ONE  = UCW'(1);

  // ---------------------------------------------------------------- packer
  // asm_r is kept full word width so INP_BYTES=1 needs no special casing:
  // shifting by 8 leaves only earlier bytes below the incoming one, and the
  // top byte is always shifted out before it could reach oreg.
  logic [INP_WIDTH-1:0] asm_r;
  logic [PCW-1:0]       pcnt_r;
  logic [INP_WIDTH-1:0] oreg_r;
  logic                 ovalid_r;
  logic [INP_WIDTH-1:0] byte_ext_s;
  logic [INP_WIDTH-1:0] word_next_s;
  logic                 pcnt_last_s;
  logic                 byte_fire_s;
  logic                 tlast_abort_s;

  assign pcnt_last_s   = (pcnt_r == PCNT_LAST);
  // The final byte of a word stalls only while oreg is full and not draining.
  assign s_byte_tready = !(pcnt_last_s && ovalid_r && !m_axis_tready);
  assign byte_fire_s   = s_byte_tvalid && s_byte_tready;
  assign m_axis_tdata  = oreg_r;
  assign m_axis_tvalid = ovalid_r;

`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
  assign tlast_abort_s = byte_fire_s && s_byte_tlast && !pcnt_last_s;
`else
  assign tlast_abort_s = 1'b0;
`endif

  // Next assembly value: previous bytes shifted up, new byte at the LSB.
  always_comb begin
    byte_ext_s      = '0;
    byte_ext_s[7:0] = s_byte_tdata;
    word_next_s     = (asm_r << 4'd8) | byte_ext_s;
  end

  // Byte counter and assembly shift register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pcnt_r <= '0;
      asm_r  <= '0;
    end else if (byte_fire_s) begin
      if (pcnt_last_s || tlast_abort_s) begin
        pcnt_r <= '0;
      end else begin
        pcnt_r <= pcnt_r + PCNT_ONE;
        asm_r  <= word_next_s;
      end
    end else begin
      pcnt_r <= pcnt_r;
    end
  end

  // Output word register: a reload on the final byte wins over a drain.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      oreg_r   <= '0;
      ovalid_r <= 1'b0;
    end else if (byte_fire_s && pcnt_last_s) begin
      oreg_r   <= word_next_s;
      ovalid_r <= 1'b1;
    end else if (ovalid_r && m_axis_tready) begin
      ovalid_r <= 1'b0;
    end else begin
      ovalid_r <= ovalid_r;
    end
  end

`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
  logic frame_err_r;
  assign frame_err = frame_err_r;

  // Sticky framing error: tlast arrived before a word was complete.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      frame_err_r <= 1'b0;
    end else if (tlast_abort_s) begin
      frame_err_r <= 1'b1;
    end else begin
      frame_err_r <= frame_err_r;
    end
  end
`endif

  // -------------------------------------------------------------- unpacker
  logic [OUT_WIDTH-1:0] ureg_r;
  logic [UCW-1:0]       ucnt_r;
  logic                 word_fire_s;
  logic                 out_fire_s;

  assign m_byte_tdata  = ureg_r[OUT_WIDTH-1 -: 8];
  assign m_byte_tvalid = (ucnt_r != '0);
  // Accept a new word when empty, or when the last byte leaves this cycle.
  assign s_axis_tready = (ucnt_r == '0) || ((ucnt_r == UCNT_ONE) && m_byte_tready);
  assign word_fire_s   = s_axis_tvalid && s_axis_tready;
  assign out_fire_s    = m_byte_tvalid && m_byte_tready;

`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
  assign m_byte_tlast  = (ucnt_r == UCNT_ONE);
`endif

  // Serializer: a word load wins over the last-byte shift, so no bubble.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ureg_r <= '0;
      ucnt_r <= '0;
    end else if (word_fire_s) begin
      ureg_r <= s_axis_tdata;
      ucnt_r <= UCNT_FULL;
    end else if (out_fire_s) begin
      if (ucnt_r > UCNT_ONE) begin
        ureg_r <= ureg_r << 4'd8;
      end else begin
        ureg_r <= ureg_r;
      end
      ucnt_r <= ucnt_r - UCNT_ONE;
    end else begin
      ucnt_r <= ucnt_r;
    end
  end

endmodule

// File: tb/tb_axis_byte_bridge.sv
// Bench for axis_byte_bridge (INP_WIDTH=16, OUT_WIDTH=24): directed
// vector table, hand-written corner sequences and a randomized phase,
// all cross-checked by a queue-based reference model sampled on negedge.
module tb_axis_byte_bridge;
  localparam int IW = 16;
  localparam int OW = 24;
  localparam int IB = IW / 8;
  localparam int OB = OW / 8;

  logic          clk = 1'b0;
  logic          arst;
  logic [7:0]    s_byte_tdata;
  logic          s_byte_tvalid;
  logic          s_byte_tready;
  logic [IW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [OW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [7:0]    m_byte_tdata;
  logic          m_byte_tvalid;
  logic          m_byte_tready;
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
  logic          s_byte_tlast;
  logic          m_byte_tlast;
  logic          frame_err;
`endif

  axis_byte_bridge #(.INP_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .arst(arst),
    .s_byte_tdata(s_byte_tdata), .s_byte_tvalid(s_byte_tvalid), .s_byte_tready(s_byte_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_byte_tdata(m_byte_tdata), .m_byte_tvalid(m_byte_tvalid), .m_byte_tready(m_byte_tready)
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
    , .s_byte_tlast(s_byte_tlast), .m_byte_tlast(m_byte_tlast), .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: plain queues of bytes and words
  logic [7:0]    pk_buf[$];     // accepted host bytes of the word being built
  logic [IW-1:0] exp_words[$];  // words owed to the processor
  logic [7:0]    exp_bytes[$];  // bytes owed to the host
  logic          exp_ferr = 1'b0;
  logic [IW-1:0] mon_w;

  always @(negedge clk) begin
    if (arst) begin
      chk("rst_m_axis_tvalid", m_axis_tvalid, 32'd0);
      chk("rst_m_axis_tdata", m_axis_tdata, 32'd0);
      chk("rst_m_byte_tvalid", m_byte_tvalid, 32'd0);
      chk("rst_m_byte_tdata", m_byte_tdata, 32'd0);
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
      chk("rst_frame_err", frame_err, 32'd0);
`endif
      pk_buf.delete();
      exp_words.delete();
      exp_bytes.delete();
      exp_ferr = 1'b0;
    end else begin
      chk("axis_valid", m_axis_tvalid, exp_words.size() != 0);
      if (m_axis_tvalid && exp_words.size() != 0) chk("axis_data", m_axis_tdata, exp_words[0]);
      chk("byte_valid", m_byte_tvalid, exp_bytes.size() != 0);
      if (m_byte_tvalid && exp_bytes.size() != 0) chk("byte_data", m_byte_tdata, exp_bytes[0]);
      chk("s_byte_tready", s_byte_tready,
          !(pk_buf.size() == IB - 1 && exp_words.size() != 0 && !m_axis_tready));
      chk("s_axis_tready", s_axis_tready,
          exp_bytes.size() == 0 || (exp_bytes.size() == 1 && m_byte_tready));
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
      chk("m_byte_tlast", m_byte_tlast, exp_bytes.size() == 1);
      chk("frame_err", frame_err, exp_ferr);
`endif
      if (m_axis_tvalid && m_axis_tready && exp_words.size() != 0) void'(exp_words.pop_front());
      if (m_byte_tvalid && m_byte_tready && exp_bytes.size() != 0) void'(exp_bytes.pop_front());
      if (s_byte_tvalid && s_byte_tready) begin
        pk_buf.push_back(s_byte_tdata);
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
        if (s_byte_tlast && pk_buf.size() < IB) begin
          pk_buf.delete();
          exp_ferr = 1'b1;
        end
`endif
        if (pk_buf.size() == IB) begin
          mon_w = '0;
          for (int k = 0; k < IB; k++) mon_w = (mon_w << 8) | IW'(pk_buf[k]);
          exp_words.push_back(mon_w);
          pk_buf.delete();
        end
      end
      if (s_axis_tvalid && s_axis_tready)
        for (int k = OB - 1; k >= 0; k--) exp_bytes.push_back(s_axis_tdata[k*8 +: 8]);
    end
  end

  // ---------------- directed vector table
  typedef struct {
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [IW-1:0] exp_word;
    logic [OW-1:0] uword;
    logic [7:0]    e0;
    logic [7:0]    e1;
    logic [7:0]    e2;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] cexp[6];
  logic       bhold;
  logic       whold;

  initial begin
    vecs[0] = '{8'hAB, 8'hCD, 16'hABCD, 24'h112233, 8'h11, 8'h22, 8'h33};
    vecs[1] = '{8'h00, 8'hFF, 16'h00FF, 24'hFF0080, 8'hFF, 8'h00, 8'h80};
    vecs[2] = '{8'h5A, 8'hA5, 16'h5AA5, 24'h010203, 8'h01, 8'h02, 8'h03};
    vecs[3] = '{8'hFF, 8'h00, 16'hFF00, 24'hDEADBE, 8'hDE, 8'hAD, 8'hBE};

    arst = 1'b0;
    s_byte_tdata = 8'h00; s_byte_tvalid = 1'b0; m_axis_tready = 1'b0;
    s_axis_tdata = '0;    s_axis_tvalid = 1'b0; m_byte_tready = 1'b0;
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
    s_byte_tlast = 1'b0;
`endif
    #2 arst = 1'b1;
    repeat (3) tick();
    arst = 1'b0;
    chk("rel_s_byte_tready", s_byte_tready, 32'd1);
    chk("rel_s_axis_tready", s_axis_tready, 32'd1);

    // Table: two bytes -> one word (latency 1, one-cycle valid); one word -> three bytes.
    m_axis_tready = 1'b1;
    m_byte_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_byte_tvalid = 1'b1; s_byte_tdata = vecs[i].b0;
      chk("vec_ready_b0", s_byte_tready, 32'd1);
      tick();
      s_byte_tdata = vecs[i].b1;
      chk("vec_no_early_word", m_axis_tvalid, 32'd0);
      tick();
      s_byte_tvalid = 1'b0;
      chk("vec_word_valid", m_axis_tvalid, 32'd1);
      chk("vec_word_data", m_axis_tdata, vecs[i].exp_word);
      tick();
      chk("vec_word_one_cycle", m_axis_tvalid, 32'd0);

      s_axis_tvalid = 1'b1; s_axis_tdata = vecs[i].uword;
      chk("vec_axis_ready", s_axis_tready, 32'd1);
      tick();
      s_axis_tvalid = 1'b0;
      chk("vec_byte0", m_byte_tdata, vecs[i].e0);
      tick();
      chk("vec_byte1", m_byte_tdata, vecs[i].e1);
      tick();
      chk("vec_byte2", m_byte_tdata, vecs[i].e2);
      chk("vec_byte2_valid", m_byte_tvalid, 32'd1);
      tick();
      chk("vec_bytes_done", m_byte_tvalid, 32'd0);
    end

    // Back-pressure: 0x0102 held, 0x04 stalls, then both words leave in order.
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_byte_tvalid = 1'b1; s_byte_tdata = 8'(i);
      chk("bp_ready_early", s_byte_tready, 32'd1);
      tick();
    end
    s_byte_tdata = 8'h04;
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall", s_byte_tready, 32'd0);
      chk("bp_hold_data", m_axis_tdata, 32'h0102);
      chk("bp_hold_valid", m_axis_tvalid, 32'd1);
      tick();
    end
    m_axis_tready = 1'b1;
    #1;
    chk("bp_ready_on_drain", s_byte_tready, 32'd1);
    tick();
    s_byte_tvalid = 1'b0;
    chk("bp_second_valid", m_axis_tvalid, 32'd1);
    chk("bp_second_data", m_axis_tdata, 32'h0304);
    tick();
    chk("bp_empty", m_axis_tvalid, 32'd0);

    // Back-to-back output words with no bubble.
    cexp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    m_byte_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 24'h112233;
    tick();
    s_axis_tdata = 24'h445566;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) s_axis_tvalid = 1'b0;
      chk("b2b_valid", m_byte_tvalid, 32'd1);
      chk("b2b_data", m_byte_tdata, cexp[i]);
      chk("b2b_axis_ready", s_axis_tready, (i == 2 || i == 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("b2b_done", m_byte_tvalid, 32'd0);

    // Reset mid-word and with an output byte pending.
    m_byte_tready = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 24'hA1B2C3;
    tick();
    s_axis_tvalid = 1'b0;
    s_byte_tvalid = 1'b1; s_byte_tdata = 8'hAB;
    tick();
    s_byte_tvalid = 1'b0;
    chk("pre_rst_byte_valid", m_byte_tvalid, 32'd1);
    arst = 1'b1;
    #1;
    chk("rst_axis_valid", m_axis_tvalid, 32'd0);
    chk("rst_axis_data", m_axis_tdata, 32'd0);
    chk("rst_byte_valid", m_byte_tvalid, 32'd0);
    chk("rst_byte_data", m_byte_tdata, 32'd0);
    tick();
    arst = 1'b0;
    chk("rst_rel_s_byte_tready", s_byte_tready, 32'd1);
    chk("rst_rel_s_axis_tready", s_axis_tready, 32'd1);
    m_byte_tready = 1'b1;
    s_byte_tvalid = 1'b1; s_byte_tdata = 8'h12;
    tick();
    s_byte_tdata = 8'h34;
    tick();
    s_byte_tvalid = 1'b0;
    chk("rst_word_valid", m_axis_tvalid, 32'd1);
    chk("rst_word_data", m_axis_tdata, 32'h1234);
    tick();

`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
    // Early tlast discards the partial word and latches frame_err.
    s_byte_tvalid = 1'b1; s_byte_tdata = 8'h77; s_byte_tlast = 1'b1;
    tick();
    s_byte_tlast = 1'b0;
    chk("tl_frame_err", frame_err, 32'd1);
    chk("tl_no_word", m_axis_tvalid, 32'd0);
    s_byte_tdata = 8'h12;
    tick();
    s_byte_tdata = 8'h34; s_byte_tlast = 1'b1;
    tick();
    s_byte_tvalid = 1'b0; s_byte_tlast = 1'b0;
    chk("tl_word_valid", m_axis_tvalid, 32'd1);
    chk("tl_word_data", m_axis_tdata, 32'h1234);
    chk("tl_err_sticky", frame_err, 32'd1);
    tick();
`endif

    // Randomized traffic on both directions; the model checks every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bhold = s_byte_tvalid && !s_byte_tready;
      whold = s_axis_tvalid && !s_axis_tready;
      @(posedge clk);
      #1;
      if (!bhold) begin
        s_byte_tvalid = ($urandom_range(0, 3) != 0);
        s_byte_tdata  = 8'($urandom);
`ifdef AXIS_BYTE_BRIDGE_TLAST_EN
        s_byte_tlast  = ($urandom_range(0, 7) == 0);
`endif
      end
      if (!whold) begin
        s_axis_tvalid = ($urandom_range(0, 2) == 0);
        s_axis_tdata  = OW'($urandom);
      end
      m_axis_tready = ($urandom_range(0, 1) == 1);
      m_byte_tready = ($urandom_range(0, 1) == 1);
    end

    // Drain: everything owed must come out.
    @(negedge clk);
    bhold = s_byte_tvalid && !s_byte_tready;
    whold = s_axis_tvalid && !s_axis_tready;
    tick();
    if (!bhold) s_byte_tvalid = 1'b0;
    if (!whold) s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    m_byte_tready = 1'b1;
    tick();
    s_byte_tvalid = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (10) tick();
    chk("drain_words", exp_words.size(), 32'd0);
    chk("drain_bytes", exp_bytes.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
